// File: rtl/mem_stage3_banked.sv
// Data-memory stage of the LD/ST pipe: NUM_LANES banks sharing one line address, fills take priority over CPU requests.
// Optional statistics counters and the stat_clr input exist only when MEM_STAGE3_STATS_EN is defined.
module mem_stage3_banked #(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int WARP_W    = 3,
  parameter int STAT_W    = 32,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   write_data,
  input  logic [NUM_LANES-1:0]          write_mask,
  input  logic [WARP_W-1:0]             warp_id,
  input  logic [1:0]                    scb_id,
  input  logic [4:0]                    reg_addr,
  input  logic [NUM_LANES-1:0]          thread_mask,
  input  logic [3*NUM_LANES-1:0]        word_offset,
  input  logic                          fill_valid,
  input  logic [ADDR_W-1:0]             fill_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   fill_data,
`ifdef MEM_STAGE3_STATS_EN
  input  logic                          stat_clr,
  output logic [STAT_W-1:0]             stat_reads_o,
  output logic [STAT_W-1:0]             stat_writes_o,
  output logic [STAT_W-1:0]             stat_fills_o,
  output logic [STAT_W-1:0]             stat_stalls_o,
`endif
  output logic                          rd_valid_o,
  output logic                          wr_ack_o,
  output logic [NUM_LANES*DATA_W-1:0]   read_data_o,
  output logic [WARP_W-1:0]             warp_id_o,
  output logic [1:0]                    scb_id_o,
  output logic [4:0]                    reg_addr_o,
  output logic [NUM_LANES-1:0]          thread_mask_o,
  output logic [3*NUM_LANES-1:0]        word_offset_o
);

  localparam int LINE_W = NUM_LANES * DATA_W;

  logic                 acc_s;
  logic                 ld_acc_s;
  logic                 st_acc_s;
  logic [NUM_LANES-1:0] wen_s;
  logic [ADDR_W-1:0]    waddr_s;
  logic [LINE_W-1:0]    wdata_s;
  logic [LINE_W-1:0]    bank_rdata_s;

  // Stage 1: request was accepted and read the banks at the previous edge.
  logic                   s1_ld_q, s1_ld_d;
  logic                   s1_st_q, s1_st_d;
  logic [WARP_W-1:0]      s1_warp_q, s1_warp_d;
  logic [1:0]             s1_scb_q, s1_scb_d;
  logic [4:0]             s1_reg_q, s1_reg_d;
  logic [NUM_LANES-1:0]   s1_tm_q, s1_tm_d;
  logic [3*NUM_LANES-1:0] s1_wo_q, s1_wo_d;

  // Stage 2: registered outputs.
  logic                   rd_valid_q, rd_valid_d;
  logic                   wr_ack_q, wr_ack_d;
  logic [LINE_W-1:0]      rdata_q, rdata_d;
  logic [WARP_W-1:0]      warp_q, warp_d;
  logic [1:0]             scb_q, scb_d;
  logic [4:0]             reg_q, reg_d;
  logic [NUM_LANES-1:0]   tm_q, tm_d;
  logic [3*NUM_LANES-1:0] wo_q, wo_d;

  assign in_ready = !fill_valid;

  // A store with mem_read also set is still only a store.
  always_comb begin
    acc_s    = in_valid && !fill_valid;
    st_acc_s = acc_s && mem_write;
    ld_acc_s = acc_s && mem_read && !mem_write;
  end

  // Bank write port: fill owns the banks whenever it is asserted.
  always_comb begin
    wen_s   = '0;
    waddr_s = mem_addr;
    wdata_s = write_data;
    if (fill_valid) begin
      wen_s   = {NUM_LANES{1'b1}};
      waddr_s = fill_addr;
      wdata_s = fill_data;
    end else if (st_acc_s) begin
      wen_s   = write_mask;
      waddr_s = mem_addr;
      wdata_s = write_data;
    end else begin
      wen_s   = '0;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Per-lane bank; contents and read register are deliberately not reset.
    always_ff @(posedge clk) begin
      if (wen_s[l]) begin
        mem_q[waddr_s] <= wdata_s[l*DATA_W +: DATA_W];
      end
      if (ld_acc_s) begin
        rd_q <= mem_q[mem_addr];
      end
    end

    assign bank_rdata_s[l*DATA_W +: DATA_W] = rd_q;
  end

  // Next state of both pipeline stages; read data holds between loads.
  always_comb begin
    s1_ld_d    = ld_acc_s;
    s1_st_d    = st_acc_s;
    s1_warp_d  = warp_id;
    s1_scb_d   = scb_id;
    s1_reg_d   = reg_addr;
    s1_tm_d    = thread_mask;
    s1_wo_d    = word_offset;
    rd_valid_d = s1_ld_q;
    wr_ack_d   = s1_st_q;
    warp_d     = s1_warp_q;
    scb_d      = s1_scb_q;
    reg_d      = s1_reg_q;
    tm_d       = s1_tm_q;
    wo_d       = s1_wo_q;
    if (s1_ld_q) begin
      rdata_d = bank_rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ld_q    <= 1'b0;
      s1_st_q    <= 1'b0;
      s1_warp_q  <= '0;
      s1_scb_q   <= 2'b00;
      s1_reg_q   <= 5'd0;
      s1_tm_q    <= '0;
      s1_wo_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      rdata_q    <= '0;
      warp_q     <= '0;
      scb_q      <= 2'b00;
      reg_q      <= 5'd0;
      tm_q       <= '0;
      wo_q       <= '0;
    end else begin
      s1_ld_q    <= s1_ld_d;
      s1_st_q    <= s1_st_d;
      s1_warp_q  <= s1_warp_d;
      s1_scb_q   <= s1_scb_d;
      s1_reg_q   <= s1_reg_d;
      s1_tm_q    <= s1_tm_d;
      s1_wo_q    <= s1_wo_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      rdata_q    <= rdata_d;
      warp_q     <= warp_d;
      scb_q      <= scb_d;
      reg_q      <= reg_d;
      tm_q       <= tm_d;
      wo_q       <= wo_d;
    end
  end

  assign rd_valid_o    = rd_valid_q;
  assign wr_ack_o      = wr_ack_q;
  assign read_data_o   = rdata_q;
  assign warp_id_o     = warp_q;
  assign scb_id_o      = scb_q;
  assign reg_addr_o    = reg_q;
  assign thread_mask_o = tm_q;
  assign word_offset_o = wo_q;

`ifdef MEM_STAGE3_STATS_EN
  logic [STAT_W-1:0] reads_q, reads_d;
  logic [STAT_W-1:0] writes_q, writes_d;
  logic [STAT_W-1:0] fills_q, fills_d;
  logic [STAT_W-1:0] stalls_q, stalls_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      sat_inc = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  // Saturating event counters; clear has priority over any increment.
  always_comb begin
    reads_d  = sat_inc(reads_q, ld_acc_s);
    writes_d = sat_inc(writes_q, st_acc_s);
    fills_d  = sat_inc(fills_q, fill_valid);
    stalls_d = sat_inc(stalls_q, in_valid && fill_valid);
    if (stat_clr) begin
      reads_d  = '0;
      writes_d = '0;
      fills_d  = '0;
      stalls_d = '0;
    end else begin
      reads_d  = reads_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      fills_q  <= '0;
      stalls_q <= '0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      fills_q  <= fills_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_reads_o  = reads_q;
  assign stat_writes_o = writes_q;
  assign stat_fills_o  = fills_q;
  assign stat_stalls_o = stalls_q;
`endif

endmodule

// File: tb/tb_mem_stage3_banked.sv
// Randomised bench for mem_stage3_banked against a line-level memory model with a queue of due responses.
module tb_mem_stage3_banked;
  localparam int NL    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int WW    = 3;
  localparam int SW    = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int LB    = NL * DW;

  typedef logic [LB-1:0] line_t;
  typedef struct {
    int               due;
    bit               ld;
    line_t            data;
    logic [WW-1:0]    warp;
    logic [1:0]       scb;
    logic [4:0]       rg;
    logic [NL-1:0]    tm;
    logic [3*NL-1:0]  wo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, mem_read, mem_write, fill_valid;
  logic [AW-1:0] mem_addr, fill_addr;
  line_t write_data, fill_data, read_data_o;
  logic [NL-1:0] write_mask, thread_mask, thread_mask_o;
  logic [WW-1:0] warp_id, warp_id_o;
  logic [1:0] scb_id, scb_id_o;
  logic [4:0] reg_addr, reg_addr_o;
  logic [3*NL-1:0] word_offset, word_offset_o;
  logic rd_valid_o, wr_ack_o;
`ifdef MEM_STAGE3_STATS_EN
  logic stat_clr;
  logic [SW-1:0] stat_reads_o, stat_writes_o, stat_fills_o, stat_stalls_o;
  logic [SW-1:0] m_reads, m_writes, m_fills, m_stalls;
`endif

  exp_t  q[$];
  line_t mem_m [DEPTH];
  line_t last_rd;
  int cyc, n_checks, n_errors;

  always #5 clk = ~clk;

  mem_stage3_banked #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(DEPTH), .WARP_W(WW), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .write_data(write_data), .write_mask(write_mask), .warp_id(warp_id),
    .scb_id(scb_id), .reg_addr(reg_addr), .thread_mask(thread_mask),
    .word_offset(word_offset), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data),
`ifdef MEM_STAGE3_STATS_EN
    .stat_clr(stat_clr), .stat_reads_o(stat_reads_o), .stat_writes_o(stat_writes_o),
    .stat_fills_o(stat_fills_o), .stat_stalls_o(stat_stalls_o),
`endif
    .rd_valid_o(rd_valid_o), .wr_ack_o(wr_ack_o), .read_data_o(read_data_o),
    .warp_id_o(warp_id_o), .scb_id_o(scb_id_o), .reg_addr_o(reg_addr_o),
    .thread_mask_o(thread_mask_o), .word_offset_o(word_offset_o)
  );

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic line_t rand_line();
    line_t r;
    for (int l = 0; l < NL; l++) r[l*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [SW-1:0] sat1(input logic [SW-1:0] v);
    return (v == {SW{1'b1}}) ? v : v + SW'(1);
  endfunction

  task automatic idle();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
    write_data = '0; write_mask = '0; warp_id = '0; scb_id = 2'd0; reg_addr = 5'd0;
    thread_mask = '0; word_offset = '0; fill_valid = 1'b0; fill_addr = '0; fill_data = '0;
`ifdef MEM_STAGE3_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  task automatic rand_tags();
    warp_id = WW'($urandom); scb_id = 2'($urandom); reg_addr = 5'($urandom);
    thread_mask = NL'($urandom); word_offset = (3*NL)'($urandom);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rd_valid", LB'(rd_valid_o), LB'(e.ld));
      chk("wr_ack", LB'(wr_ack_o), LB'(!e.ld));
      if (e.ld) last_rd = e.data;
      chk("warp_id_o", LB'(warp_id_o), LB'(e.warp));
      chk("scb_id_o", LB'(scb_id_o), LB'(e.scb));
      chk("reg_addr_o", LB'(reg_addr_o), LB'(e.rg));
      chk("thread_mask_o", LB'(thread_mask_o), LB'(e.tm));
      chk("word_offset_o", LB'(word_offset_o), LB'(e.wo));
    end else begin
      chk("rd_valid_idle", LB'(rd_valid_o), LB'(1'b0));
      chk("wr_ack_idle", LB'(wr_ack_o), LB'(1'b0));
    end
    chk("read_data", read_data_o, last_rd);
`ifdef MEM_STAGE3_STATS_EN
    chk("stat_reads", LB'(stat_reads_o), LB'(m_reads));
    chk("stat_writes", LB'(stat_writes_o), LB'(m_writes));
    chk("stat_fills", LB'(stat_fills_o), LB'(m_fills));
    chk("stat_stalls", LB'(stat_stalls_o), LB'(m_stalls));
`endif
  endtask

  // Called at posedge+1 with this cycle's inputs applied; returns at posedge+1 of the next cycle.
  task automatic tick();
    exp_t e;
    bit acc;
    #1;
    chk("in_ready", LB'(in_ready), LB'(!fill_valid));
    acc = in_valid && !fill_valid;
`ifdef MEM_STAGE3_STATS_EN
    if (stat_clr) begin
      m_reads = '0; m_writes = '0; m_fills = '0; m_stalls = '0;
    end else begin
      if (acc && mem_read && !mem_write) m_reads = sat1(m_reads);
      if (acc && mem_write) m_writes = sat1(m_writes);
      if (fill_valid) m_fills = sat1(m_fills);
      if (in_valid && fill_valid) m_stalls = sat1(m_stalls);
    end
`endif
    if (fill_valid) mem_m[fill_addr] = fill_data;
    if (acc && (mem_read || mem_write)) begin
      e.due = cyc + 2; e.ld = !mem_write; e.data = mem_m[mem_addr];
      e.warp = warp_id; e.scb = scb_id; e.rg = reg_addr; e.tm = thread_mask; e.wo = word_offset;
      if (mem_write)
        for (int l = 0; l < NL; l++)
          if (write_mask[l]) mem_m[mem_addr][l*DW +: DW] = write_data[l*DW +: DW];
      q.push_back(e);
    end
    @(posedge clk); #1; cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    q.delete();
    last_rd = '0;
`ifdef MEM_STAGE3_STATS_EN
    m_reads = '0; m_writes = '0; m_fills = '0; m_stalls = '0;
`endif
    #2;
    chk("rst_rd_valid", LB'(rd_valid_o), LB'(1'b0));
    chk("rst_wr_ack", LB'(wr_ack_o), LB'(1'b0));
    chk("rst_read_data", read_data_o, '0);
    chk("rst_tags", LB'({warp_id_o, scb_id_o, reg_addr_o, thread_mask_o, word_offset_o}), '0);
    @(posedge clk); #1; cyc++;
    chk("rst_hold_rd_valid", LB'(rd_valid_o), LB'(1'b0));
    reset = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [WW-1:0] w);
    idle(); rand_tags(); in_valid = 1'b1; mem_read = 1'b1; mem_addr = a; warp_id = w;
    tick();
  endtask

  initial begin
    line_t d;
    n_checks = 0; n_errors = 0; cyc = 0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Give every line known contents, with CPU loads stalled behind the fills.
    for (int a = 0; a < DEPTH; a++) begin
      idle(); fill_valid = 1'b1; fill_addr = AW'(a); fill_data = rand_line();
      in_valid = 1'($urandom); mem_read = 1'b1; mem_addr = AW'($urandom);
      tick();
    end

    // Masked store over a fill, then load.
    idle(); fill_valid = 1'b1; fill_addr = AW'(10);
    for (int k = 0; k < NL; k++) fill_data[k*DW +: DW] = DW'(k * 17);
    tick();
    idle(); in_valid = 1'b1; mem_write = 1'b1; mem_addr = AW'(10); write_mask = NL'(5);
    d = rand_line(); d[0 +: DW] = DW'(10); d[2*DW +: DW] = DW'(11); write_data = d;
    tick();
    load(AW'(10), WW'(4));
    idle(); tick(); tick();
    chk("t1_lane0", LB'(read_data_o[0 +: DW]), LB'(DW'(10)));
    chk("t1_lane1", LB'(read_data_o[DW +: DW]), LB'(DW'(17)));
    chk("t1_lane2", LB'(read_data_o[2*DW +: DW]), LB'(DW'(11)));
    chk("t1_lane3", LB'(read_data_o[3*DW +: DW]), LB'(DW'(51)));

    // Fill and CPU in the same cycle: CPU waits one cycle.
`ifdef MEM_STAGE3_STATS_EN
    idle(); stat_clr = 1'b1; tick();
`endif
    idle(); fill_valid = 1'b1; fill_addr = AW'(20); fill_data = rand_line();
    in_valid = 1'b1; mem_read = 1'b1; mem_addr = AW'(20);
    tick();
`ifdef MEM_STAGE3_STATS_EN
    chk("t2_stalls", LB'(stat_stalls_o), LB'(SW'(1)));
    chk("t2_fills", LB'(stat_fills_o), LB'(SW'(1)));
`endif
    load(AW'(20), WW'(2));

    // Back-to-back loads, then read-after-fill and read-after-store.
    load(AW'(1), WW'(1)); load(AW'(2), WW'(2)); load(AW'(3), WW'(3));
    idle(); fill_valid = 1'b1; fill_addr = AW'(5); fill_data = rand_line(); tick();
    load(AW'(5), WW'(5));
    idle(); rand_tags(); in_valid = 1'b1; mem_write = 1'b1; mem_addr = AW'(6);
    write_mask = NL'($urandom); write_data = rand_line(); tick();
    load(AW'(6), WW'(6));
    idle(); tick(); tick();

    // Reset one cycle after a load is accepted; bank contents survive.
    load(AW'(7), WW'(7));
    do_reset();
    idle(); tick(); tick();
    load(AW'(7), WW'(1));
    idle(); tick(); tick();

`ifdef MEM_STAGE3_STATS_EN
    for (int i = 0; i < 4; i++) load(AW'(i), WW'(i));
    for (int i = 0; i < 2; i++) begin
      idle(); rand_tags(); in_valid = 1'b1; mem_write = 1'b1; mem_addr = AW'(i + 30);
      write_mask = NL'($urandom); write_data = rand_line(); tick();
    end
    idle(); in_valid = 1'b1; mem_read = 1'b1; mem_addr = AW'(9); stat_clr = 1'b1; tick();
    chk("t6_reads_clr", LB'(stat_reads_o), '0);
    chk("t6_writes_clr", LB'(stat_writes_o), '0);
`endif

    // Random traffic on a small address window to provoke read-after-write hits.
    for (int i = 0; i < 1500; i++) begin
      int op;
      idle(); rand_tags();
      op = int'($urandom_range(0, 9));
      in_valid = ($urandom_range(0, 3) != 0);
      mem_read = (op < 5) || (op == 8);
      mem_write = (op >= 5) && (op <= 8);
      mem_addr = AW'($urandom_range(0, 15));
      write_mask = NL'($urandom); write_data = rand_line();
      fill_valid = ($urandom_range(0, 4) == 0);
      fill_addr = AW'($urandom_range(0, 15)); fill_data = rand_line();
`ifdef MEM_STAGE3_STATS_EN
      stat_clr = ($urandom_range(0, 63) == 0);
`endif
      tick();
    end
    idle(); tick(); tick(); tick();
    chk("queue_drained", LB'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
